// File: rtl/clk_stim_gen.sv
// rtl/clk_stim_gen.sv - burst stimulus clock generator with programmable half-period, count and start delay
module clk_stim_gen #(
   parameter int CNT_W      = 8,
   parameter int EDGE_W     = 16,
   parameter int INIT_DELAY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic [CNT_W-1:0]  half_period,
   input  logic [EDGE_W-1:0] num_edges,
   output logic              clk_out,
   output logic              busy,
   output logic              done,
   output logic [EDGE_W-1:0] edge_count
);

   typedef enum logic [2:0] {IDLE, DELAY, HIGH, LOW, DONE} state_t;

   localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(INIT_DELAY - 1);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  hp;
   logic [EDGE_W-1:0] num;
   logic              stop_l;
   logic              stop_seen;
   logic              last_edge;

   // A stop arriving on the deciding edge counts as well as one latched earlier
   assign stop_seen = stop_l | stop;
   assign last_edge = (num != '0) && (edge_count == num);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         hp         <= '0;
         num        <= '0;
         stop_l     <= 1'b0;
         clk_out    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         edge_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  hp         <= (half_period == '0) ? CNT_W'(1) : half_period;
                  num        <= num_edges;
                  edge_count <= '0;
                  busy       <= 1'b1;
                  stop_l     <= 1'b0;
                  cnt        <= DLY_LOAD;
                  state      <= DELAY;
               end
            end
            DELAY: begin
               if (stop_seen) begin
                  state   <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  clk_out <= 1'b0;
               end else if (cnt == '0) begin
                  state      <= HIGH;
                  clk_out    <= 1'b1;
                  edge_count <= edge_count + EDGE_W'(1);
                  cnt        <= hp - CNT_W'(1);
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            HIGH: begin
               if (stop) stop_l <= 1'b1;
               if (cnt == '0) begin
                  state   <= LOW;
                  clk_out <= 1'b0;
                  cnt     <= hp - CNT_W'(1);
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            LOW: begin
               if (stop) stop_l <= 1'b1;
               // Termination is only decided after a full low phase, so no runt pulses
               if (cnt == '0) begin
                  if (stop_seen || last_edge) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state      <= HIGH;
                     clk_out    <= 1'b1;
                     edge_count <= edge_count + EDGE_W'(1);
                     cnt        <= hp - CNT_W'(1);
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DONE: begin
               done    <= 1'b0;
               clk_out <= 1'b0;
               stop_l  <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state   <= IDLE;
               clk_out <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clk_stim_gen.sv
// tb/tb_clk_stim_gen.sv - randomized self-checking bench for clk_stim_gen against a waveform model
module tb_clk_stim_gen;

   localparam int D = 2;

   logic        clk;
   logic        reset;
   logic        start;
   logic        stop;
   logic [7:0]  half_period;
   logic [15:0] num_edges;
   logic        clk_out;
   logic        busy;
   logic        done;
   logic [15:0] edge_count;

   int vectors;
   int miscompares;

   clk_stim_gen #(.CNT_W(8), .EDGE_W(16), .INIT_DELAY(D)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .half_period(half_period), .num_edges(num_edges),
      .clk_out(clk_out), .busy(busy), .done(done), .edge_count(edge_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected waveform from closed-form rules: rise i at k=D+2*hp*i, high for hp cycles,
   // burst ends at E; stop at k_s<=D ends it at k_s with no rises.
   task automatic apply_burst(input int hp_in, input int num_in, input int ks, input string name);
      int hpe, r, e, j, ec_exp;
      logic ek, eb, ed;
      hpe = (hp_in == 0) ? 1 : hp_in;
      if (ks >= 1 && ks <= D) begin
         r = 0;
         e = ks;
      end else if (ks > D) begin
         j = (ks - D + 2 * hpe - 1) / (2 * hpe);
         r = (num_in != 0 && num_in < j) ? num_in : j;
         e = D + 2 * hpe * r;
      end else begin
         r = num_in;
         e = D + 2 * hpe * r;
      end
      half_period = 8'(hp_in);
      num_edges   = 16'(num_in);
      start       = 1'b1;
      stop        = (ks == 0);
      for (int k = 0; k <= e + 1; k++) begin
         @(posedge clk);
         #1;
         start       = 1'b0;
         stop        = 1'b0;
         half_period = 8'($urandom);
         num_edges   = 16'($urandom);
         if (k + 1 <= e && $urandom_range(0, 3) == 0) start = 1'b1;
         if (k + 1 == ks) stop = 1'b1;
         if (k < e) begin
            eb = 1'b1;
            ed = 1'b0;
            ec_exp = (k >= D) ? (k - D) / (2 * hpe) + 1 : 0;
            ek = (k >= D) && (((k - D) % (2 * hpe)) < hpe);
         end else begin
            eb = 1'b0;
            ed = (k == e);
            ek = 1'b0;
            ec_exp = r;
         end
         vectors += 4;
         if (clk_out !== ek) begin
            miscompares++;
            $display("FAIL %s clk_out k=%0d got %b exp %b", name, k, clk_out, ek);
         end
         if (busy !== eb) begin
            miscompares++;
            $display("FAIL %s busy k=%0d got %b exp %b", name, k, busy, eb);
         end
         if (done !== ed) begin
            miscompares++;
            $display("FAIL %s done k=%0d got %b exp %b", name, k, done, ed);
         end
         if (edge_count !== 16'(ec_exp)) begin
            miscompares++;
            $display("FAIL %s edge_count k=%0d got %0d exp %0d", name, k, edge_count, ec_exp);
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      half_period = '0;
      num_edges   = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({clk_out, busy, done, edge_count} !== 19'd0) begin
         miscompares++;
         $display("FAIL reset_state got %b%b%b/%0d exp 000/0", clk_out, busy, done, edge_count);
      end
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         vectors++;
         if ({clk_out, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_release k=%0d got %b%b%b exp 000", k, clk_out, busy, done);
         end
      end
   endtask

   task automatic test_basic;
      apply_burst(3, 4, -1, "basic_hp3_n4");
   endtask

   task automatic test_hp_zero;
      apply_burst(0, 3, -1, "hp0_n3");
   endtask

   task automatic test_free_run_stop;
      apply_burst(2, 0, D + 9, "freerun_stop_high");
      apply_burst(1, 0, D + 7, "freerun_stop_low");
   endtask

   task automatic test_stop_delay;
      apply_burst(3, 4, 1, "stop_delay_k1");
      apply_burst(3, 4, D, "stop_delay_kD");
   endtask

   task automatic test_start_stop_same;
      apply_burst(1, 2, 0, "start_stop_same");
   endtask

   task automatic test_back_to_back;
      apply_burst(1, 1, -1, "b2b_a");
      apply_burst(2, 2, -1, "b2b_b");
   endtask

   task automatic test_random;
      int hp_r, num_r, ks_r;
      for (int i = 0; i < 25; i++) begin
         hp_r  = $urandom_range(0, 5);
         num_r = $urandom_range(0, 6);
         if (num_r == 0) ks_r = $urandom_range(1, 40);
         else if ($urandom_range(0, 2) == 0) ks_r = -1;
         else ks_r = $urandom_range(0, D + 2 * ((hp_r == 0) ? 1 : hp_r) * num_r + 2);
         apply_burst(hp_r, num_r, ks_r, "random");
      end
   endtask

   task automatic test_reset_mid;
      half_period = 8'd3;
      num_edges   = 16'd4;
      start       = 1'b1;
      // Second rise lands on k=8; reset goes in on the edge after k=9
      for (int k = 0; k <= 9; k++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      vectors++;
      if (edge_count !== 16'd2) begin
         miscompares++;
         $display("FAIL reset_mid_pre edge_count got %0d exp 2", edge_count);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      vectors++;
      if ({clk_out, busy, done, edge_count} !== 19'd0) begin
         miscompares++;
         $display("FAIL reset_mid_state got %b%b%b/%0d exp 000/0", clk_out, busy, done, edge_count);
      end
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         #1;
         vectors++;
         if ({clk_out, busy, done, edge_count} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_mid_after k=%0d got %b%b%b/%0d exp 000/0", k, clk_out, busy, done, edge_count);
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_basic();
      test_hp_zero();
      test_free_run_stop();
      test_stop_delay();
      test_start_stop_same();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
